// File: rtl/controller_pkg.sv
// ---------------------------------------------------------------------------
// controller_pkg
//   Shared definitions for the registered 4-bit logic-gate controller.
//   - op_t  : gate select codes, in the same encoding as {S1,S0}
//   - A_W, B_W, Y_W : fixed operand and result widths
// ---------------------------------------------------------------------------
package controller_pkg;

    localparam int A_W = 4;
    localparam int B_W = 2;
    localparam int Y_W = 4;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

endpackage : controller_pkg

// File: rtl/controller_gate_unit.sv
// ---------------------------------------------------------------------------
// controller_gate_unit
//   Purely combinational bitwise gate applied to two Y_W-bit operands.
//   Ports:
//     a   input  [Y_W-1:0]  operand A
//     bx  input  [Y_W-1:0]  operand B, already zero-extended by the caller
//     op  input  op_t       gate select
//     y   output [Y_W-1:0]  gate result
// ---------------------------------------------------------------------------
module controller_gate_unit
    import controller_pkg::*;
(
    input  logic [Y_W-1:0] a,
    input  logic [Y_W-1:0] bx,
    input  op_t            op,
    output logic [Y_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & bx;
            OP_OR:   y = a | bx;
            OP_XOR:  y = a ^ bx;
            OP_NAND: y = ~(a & bx);
            default: y = '0;
        endcase
    end

endmodule : controller_gate_unit

// File: rtl/controller.sv
// ---------------------------------------------------------------------------
// controller
//   Registered 4-bit logic-gate controller. Each rising edge samples the
//   enable, select and operands and updates both outputs; nothing else is
//   remembered between edges.
//   Ports:
//     clk  input       rising-edge clock
//     rst  input       synchronous active-high reset, clears Y and D
//     I    input       enable: 1 = evaluate, 0 = next outputs are zero
//     S1   input       select MSB
//     S0   input       select LSB
//     A    input  [3]  operand A
//     B    input  [1]  operand B (zero-extended to 4 bits internally)
//     Y    output [3]  registered gate result
//     D    output [3]  registered one-hot decode of {S1,S0}
//   No handshake: inputs are consumed unconditionally every cycle and the
//   outputs are valid one edge later; there is no backpressure.
// ---------------------------------------------------------------------------
module controller
    import controller_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           I,
    input  logic           S1,
    input  logic           S0,
    input  logic [A_W-1:0] A,
    input  logic [B_W-1:0] B,
    output logic [Y_W-1:0] Y,
    output logic [Y_W-1:0] D
);

    logic [1:0]     sel;
    op_t            op;
    logic [Y_W-1:0] bx;
    logic [Y_W-1:0] gate_y;
    logic [Y_W-1:0] dec;

    logic [Y_W-1:0] y_d, y_q;
    logic [Y_W-1:0] d_d, d_q;

    assign sel = {S1, S0};
    assign op  = op_t'(sel);
    assign bx  = {{(Y_W-B_W){1'b0}}, B};

    controller_gate_unit u_gate (
        .a  (A),
        .bx (bx),
        .op (op),
        .y  (gate_y)
    );

    // One-hot decode of the select code.
    always_comb begin
        dec = '0;
        dec[sel] = 1'b1;
    end

    // Enable low forces both next outputs to zero regardless of other inputs.
    always_comb begin
        y_d = '0;
        d_d = '0;
        if (I) begin
            y_d = gate_y;
            d_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
            d_q <= '0;
        end else begin
            y_q <= y_d;
            d_q <= d_d;
        end
    end

    assign Y = y_q;
    assign D = d_q;

endmodule : controller

// File: tb/tb_controller.sv
// ---------------------------------------------------------------------------
// tb_controller
//   Directed self-checking bench for controller. Inputs change #1 after a
//   rising edge; outputs are sampled at that same point (away from the edge).
// ---------------------------------------------------------------------------
module tb_controller;

  logic       clk;
  logic       rst;
  logic       I;
  logic       S1;
  logic       S0;
  logic [3:0] A;
  logic [1:0] B;
  logic [3:0] Y;
  logic [3:0] D;

  int checks;
  int errors;

  controller dut (
    .clk (clk),
    .rst (rst),
    .I   (I),
    .S1  (S1),
    .S0  (S0),
    .A   (A),
    .B   (B),
    .Y   (Y),
    .D   (D)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1;
    I   = 1'b0;
    S1  = 1'b0;
    S0  = 1'b0;
    A   = 4'h0;
    B   = 2'h0;
  end

  // driver tasks
  task automatic drive(input logic en, input logic [1:0] sel,
                       input logic [3:0] a, input logic [1:0] b);
    I  = en;
    S1 = sel[1];
    S0 = sel[0];
    A  = a;
    B  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [3:0] exp_y,
                           input logic [3:0] exp_d);
    checks++;
    if (Y !== exp_y || D !== exp_d) begin
      errors++;
      $display("FAIL %s: Y=%b D=%b expected Y=%b D=%b", name, Y, D, exp_y, exp_d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'b10, 4'b1111, 2'b11);
    tick();
    check_out("reset_edge1", 4'b0000, 4'b0000);
    tick();
    check_out("reset_edge2", 4'b0000, 4'b0000);
    rst = 1'b0;
  endtask

  task automatic test_gate_sweep();
    logic [3:0] exp_y [4];
    logic [3:0] exp_d [4];
    exp_y = '{4'b0010, 4'b1110, 4'b1100, 4'b1101};
    exp_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 2'(s), 4'b1110, 2'b10);
      tick();
      check_out($sformatf("sweep_sel%0d", s), exp_y[s], exp_d[s]);
    end
  endtask

  task automatic test_enable_low();
    drive(1'b0, 2'b11, 4'b1010, 2'b01);
    tick();
    check_out("enable_low", 4'b0000, 4'b0000);
    drive(1'b1, 2'b11, 4'b1010, 2'b01);
    tick();
    check_out("enable_high_nand", 4'b1111, 4'b1000);
  endtask

  task automatic test_latency();
    drive(1'b1, 2'b00, 4'b0101, 2'b11);
    tick();
    check_out("latency_and", 4'b0001, 4'b0001);
    #2;
    drive(1'b1, 2'b01, 4'b0101, 2'b11);
    #1;
    check_out("latency_hold", 4'b0001, 4'b0001);
    tick();
    check_out("latency_or", 4'b0111, 4'b0010);
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 2'b10, 4'b1110, 2'b10);
    tick();
    check_out("prio_pre", 4'b1100, 4'b0100);
    rst = 1'b1;
    drive(1'b1, 2'b01, 4'b1110, 2'b10);
    tick();
    check_out("prio_reset", 4'b0000, 4'b0000);
    rst = 1'b0;
    tick();
    check_out("prio_release", 4'b1110, 4'b0010);
  endtask

  task automatic test_boundary();
    logic [3:0] exp_y [4];
    logic [3:0] exp_d [4];
    exp_y = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};
    exp_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 2'(s), 4'b0000, 2'b00);
      tick();
      check_out($sformatf("zero_sel%0d", s), exp_y[s], exp_d[s]);
    end
    // all-ones operands: Bx=0011
    drive(1'b1, 2'b10, 4'b1111, 2'b11);
    tick();
    check_out("ones_xor", 4'b1100, 4'b0100);
  endtask

  task automatic test_back_to_back();
    // enable toggles every cycle with changing operands
    drive(1'b1, 2'b01, 4'b1000, 2'b01);
    tick();
    check_out("b2b_or", 4'b1001, 4'b0010);
    drive(1'b0, 2'b01, 4'b1000, 2'b01);
    tick();
    check_out("b2b_off", 4'b0000, 4'b0000);
    drive(1'b1, 2'b00, 4'b0111, 2'b11);
    tick();
    check_out("b2b_and", 4'b0011, 4'b0001);
  endtask

  // final report
  initial begin
    checks = 0;
    errors = 0;
    @(negedge clk);
    test_reset();
    test_gate_sweep();
    test_enable_low();
    test_latency();
    test_reset_priority();
    test_boundary();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_controller
